// File: rtl/switch_endpoint.sv
// rtl/switch_endpoint.sv - core-side switch endpoint: posted-send FIFO plus blocking-receive sequencer
// Payload lanes carry IEEE-754 single-precision bit patterns, 32 bits per lane.
module switch_endpoint #(
  parameter int WIDTH          = 2,
  parameter int CORE_SIZE      = 3,
  parameter int CORE_ID        = 0,
  parameter int SEND_DEPTH     = 2,
  parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic                          cmd_op,
  input  logic [CORE_ADDR_SIZE-1:0]     cmd_core_idx,
  input  logic [WIDTH-1:0][31:0]        cmd_data,
  output logic                          cmd_ready,
  output logic                          cmd_error,
  output logic                          rsp_valid,
  output logic [CORE_ADDR_SIZE-1:0]     rsp_src,
  output logic [WIDTH-1:0][31:0]        rsp_data,
  output logic                          idle,
  output logic                          send_ready,
  output logic [CORE_ADDR_SIZE-1:0]     send_core_idx,
  output logic [WIDTH-1:0][31:0]        send_data,
  input  logic                          send_ok,
  output logic                          recv_request,
  output logic [CORE_ADDR_SIZE-1:0]     recv_core_idx,
  input  logic                          recv_ready,
  input  logic [WIDTH-1:0][31:0]        recv_data
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rstate_e;

  localparam int PTR_W = (SEND_DEPTH > 1) ? $clog2(SEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(SEND_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(SEND_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(SEND_DEPTH);
  localparam logic [31:0]      CORE_SIZE_U = 32'(CORE_SIZE);
  localparam logic [31:0]      CORE_ID_U   = 32'(CORE_ID);

  rstate_e rstate_q, rstate_d;

  logic [CORE_ADDR_SIZE-1:0] dst_mem_q [SEND_DEPTH];
  logic [WIDTH-1:0][31:0]    data_mem_q [SEND_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;

  logic [CORE_ADDR_SIZE-1:0] recv_idx_q, recv_idx_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [CORE_ADDR_SIZE-1:0] rsp_src_q, rsp_src_d;
  logic [WIDTH-1:0][31:0]    rsp_data_q, rsp_data_d;
  logic                      cmd_error_q;
  logic                      idle_q;

  logic illegal, accept, push, pop, recv_start;

  assign illegal    = (32'(cmd_core_idx) >= CORE_SIZE_U) || (32'(cmd_core_idx) == CORE_ID_U);
  // Readiness uses pre-edge occupancy, so a same-cycle pop never admits a push into a full FIFO.
  assign cmd_ready  = cmd_op ? (rstate_q == R_IDLE) : (count_q != FULL_CNT);
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && !cmd_op && !illegal;
  assign recv_start = accept && cmd_op && !illegal;
  assign pop        = (count_q != '0) && send_ok;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    rstate_d    = rstate_q;
    recv_idx_d  = recv_idx_q;
    rsp_valid_d = 1'b0;
    rsp_src_d   = rsp_src_q;
    rsp_data_d  = rsp_data_q;
    case (rstate_q)
      R_IDLE: begin
        if (recv_start) begin
          recv_idx_d = cmd_core_idx;
          rstate_d   = R_REQ;
        end
      end
      R_REQ: rstate_d = R_WAIT;
      R_WAIT: begin
        if (recv_ready) begin
          rsp_valid_d = 1'b1;
          rsp_src_d   = recv_idx_q;
          rsp_data_d  = recv_data;
          rstate_d    = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_q    <= R_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      recv_idx_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= '0;
      rsp_data_q  <= '0;
      cmd_error_q <= 1'b0;
      idle_q      <= 1'b1;
      for (int i = 0; i < SEND_DEPTH; i++) begin
        dst_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      rstate_q    <= rstate_d;
      count_q     <= count_d;
      recv_idx_q  <= recv_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_data_q  <= rsp_data_d;
      cmd_error_q <= accept && illegal;
      idle_q      <= (count_d == '0) && (rstate_d == R_IDLE);
      if (push) begin
        dst_mem_q[wr_ptr_q]  <= cmd_core_idx;
        data_mem_q[wr_ptr_q] <= cmd_data;
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  assign send_ready    = (count_q != '0);
  assign send_core_idx = dst_mem_q[rd_ptr_q];
  assign send_data     = data_mem_q[rd_ptr_q];
  assign recv_request  = (rstate_q == R_REQ);
  assign recv_core_idx = recv_idx_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_src       = rsp_src_q;
  assign rsp_data      = rsp_data_q;
  assign cmd_error     = cmd_error_q;
  assign idle          = idle_q;

endmodule

// File: doc/switch_endpoint.md
# switch_endpoint

Core-side endpoint for the inter-core `Switch`. It sits inside each core, between the core's send/receive command stream and one port of the switch. It buffers outgoing messages in a small FIFO so that posted sends do not stall the core, and it sequences blocking receives through the switch's request/response protocol. It also rejects illegal destinations and reports idle status to the core.

## Interface

Parameters:
- `WIDTH`, 2, number of shortreal (IEEE-754 single) lanes per message
- `CORE_SIZE`, 3, number of cores on the switch
- `CORE_ID`, 0, index of the core that owns this endpoint
- `SEND_DEPTH`, 2, send FIFO entries (≥1)
- `CORE_ADDR_SIZE`, `$clog2(CORE_SIZE)`, core index width

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  core presents a command
- `cmd_op`  in  1  0 = SEND, 1 = RECV
- `cmd_core_idx`  in  CORE_ADDR_SIZE  destination (SEND) or source (RECV)
- `cmd_data`  in  shortreal[WIDTH]  SEND payload
- `cmd_ready`  out  1  command accepted this cycle (combinational)
- `cmd_error`  out  1  one-cycle pulse: the last accepted command was illegal and dropped
- `rsp_valid`  out  1  one-cycle pulse: received message valid
- `rsp_src`  out  CORE_ADDR_SIZE  source core of the received message
- `rsp_data`  out  shortreal[WIDTH]  received payload
- `idle`  out  1  FIFO empty and receive FSM in R_IDLE
- `send_ready`  out  1  head message offered to the switch
- `send_core_idx`  out  CORE_ADDR_SIZE  head destination
- `send_data`  out  shortreal[WIDTH]  head payload
- `send_ok`  in  1  switch can take this core's message
- `recv_request`  out  1  one-cycle receive request pulse
- `recv_core_idx`  out  CORE_ADDR_SIZE  requested source core
- `recv_ready`  in  1  switch delivers the message (one-cycle pulse)
- `recv_data`  in  shortreal[WIDTH]  delivered payload, valid while `recv_ready` is high

## Operation

- **Command accept:** a command is accepted at a rising edge when `cmd_valid && cmd_ready`. At most one command is accepted per cycle.
- **SEND readiness:** for SEND, `cmd_ready = (count != SEND_DEPTH)`. A same-cycle dequeue does not free a slot.
- **RECV readiness:** for RECV, `cmd_ready = (rstate == R_IDLE)`.
- **Illegal commands:** a command is illegal if `cmd_core_idx >= CORE_SIZE` or `cmd_core_idx == CORE_ID`. An illegal command is still accepted, but it is dropped: no enqueue and no FSM change. `cmd_error` pulses on the next cycle.
- **Send FIFO:** circular buffer with read/write pointers that wrap modulo `SEND_DEPTH`, plus a count register.
- **Send output:** `send_ready = (count != 0)`. `send_core_idx` and `send_data` show the head entry and hold stable until it transfers.
- **Transfer:** a message transfers at a rising edge with `send_ready && send_ok`; that edge pops the head.
- **Simultaneous push and pop** (not full): count is unchanged and FIFO order is preserved.
- **Receive FSM:**
  - R_IDLE: an accepted legal RECV latches the index into `recv_core_idx` → R_REQ.
  - R_REQ: `recv_request = 1` for exactly one cycle → R_WAIT.
  - R_WAIT: hold until `recv_ready`; at that edge register `recv_data` into `rsp_data` and `recv_core_idx` into `rsp_src`, set `rsp_valid` → R_IDLE.
- `recv_ready` in R_IDLE or R_REQ is ignored.
- Sends and receives are independent. A pending RECV never blocks the send FIFO, and sends never block a RECV.
- **Reset values:**
  - 0: `send_ready`, `recv_request`, `rsp_valid`, `cmd_error`, FIFO count and pointers
  - 0: `send_core_idx`, `recv_core_idx`, `rsp_src`
  - 0.0: `rsp_data` lanes
  - 1: `idle`
  - FSM state: R_IDLE
- **Reset mid-operation:** queued messages and any pending receive are discarded. A stale `recv_ready` arriving after reset is ignored.

## Timing

- **SEND:** accepted at edge N → `send_ready` high after N. The earliest transfer is at edge N+1 if `send_ok` is high.
- **RECV:** accepted at edge N → `recv_request` high for the cycle after N. `recv_ready` at edge M → `rsp_valid` high for one cycle after M. Minimum command-to-response latency is 3 cycles.
- `rsp_valid` and `cmd_error` are registered one-cycle pulses.
- `idle` is registered and reflects state after the current edge.

## Test plan

- **Reset:** hold `reset` for 1 cycle → every output at its listed reset value; `idle = 1`; `cmd_ready = 1` for both ops.
- **Single send:** CORE_ID=2, SEND to 1 with {11,13}, `send_ok = 1` → next cycle `send_ready = 1`, `send_core_idx = 1`, data {11,13}; one cycle later `send_ready = 0` and `idle = 1`.
- **Backpressure:** `send_ok = 0`, issue SENDs to 0 with {123,456}, {444,666}, {7,8}, SEND_DEPTH=2 → first two accepted, `cmd_ready = 0` for the third. Raise `send_ok` → heads appear in order {123,456}, {444,666}, then {7,8} once accepted.
- **Receive:** RECV from 2; switch returns `recv_ready` 5 cycles after the request with {11,13} → exactly one `recv_request` pulse with `recv_core_idx = 2`; `rsp_valid` one cycle later with `rsp_src = 2` and {11,13}. A second RECV issued during R_WAIT sees `cmd_ready = 0`.
- **Illegal commands:** SEND to CORE_ID, then RECV from index 3 (CORE_SIZE=3) → each accepted; `cmd_error` pulses next cycle; no `send_ready` or `recv_request` activity.
- **Reset mid-operation:** 2 queued sends plus RECV in R_WAIT, assert `reset`, then pulse `recv_ready` → FIFO empty, no `rsp_valid`, `idle = 1`.
